dma_engine: RTL and testbench



---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_regs.sv | 79 +++++++
 rtl/dma_engine.sv | 121 ++++++++++++
 tb/tb_dma_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: register offsets, CTRL/STATUS bit indices and FSM encoding for dma_engine
package dma_pkg;
   localparam logic [2:0] OFF_SRC_LO = 3'd0;
   localparam logic [2:0] OFF_SRC_HI = 3'd1;
   localparam logic [2:0] OFF_DST_LO = 3'd2;
   localparam logic [2:0] OFF_DST_HI = 3'd3;
   localparam logic [2:0] OFF_LEN_LO = 3'd4;
   localparam logic [2:0] OFF_LEN_HI = 3'd5;
   localparam logic [2:0] OFF_CTRL = 3'd6;
   localparam int CTRL_START = 0;
   localparam int CTRL_FILL = 1;
   localparam int CTRL_ABORT = 2;
   typedef enum logic [2:0] {IDLE, REQ, RD, CAP, WR, FIN} dmaState;
endpackage

// File: rtl/dma_regs.sv
// dma_regs: CPU-visible register file, decode and registered readback (CTRL bit1 is FILL only with DMA_FILL_EN)
module dma_regs
   import dma_pkg::*;
#(
   parameter logic [15:0] REG_BASE = 16'h1010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cfgAddress,
   input  logic [7:0]  cfgDin,
   input  logic        cfgWEn,
   input  logic        cfgREn,
   input  logic        busy,
   input  logic        doneSet,
   input  logic        abortSet,
   output logic        startStb,
   output logic        abortStb,
   output logic        fillSel,
   output logic [15:0] srcVal,
   output logic [15:0] dstVal,
   output logic [15:0] lenVal,
   output logic [7:0]  cfgDout
);
   logic [15:0] off;
   logic hit, ctrlWr, done, aborted;
   logic [7:0] rdData;
   assign off = cfgAddress - REG_BASE;
   assign hit = off < 16'd7;
   assign ctrlWr = cfgWEn && hit && off[2:0] == OFF_CTRL;
   // ABORT beats START in the same write, and ABORT means nothing while idle
   assign startStb = ctrlWr && cfgDin[CTRL_START] && !cfgDin[CTRL_ABORT] && !busy;
   assign abortStb = ctrlWr && cfgDin[CTRL_ABORT] && busy;
`ifdef DMA_FILL_EN
   assign fillSel = cfgDin[CTRL_FILL];
`else
   assign fillSel = 1'b0;
`endif
   always_comb begin
      rdData = 8'h00;
      case (off[2:0])
         OFF_SRC_LO: rdData = srcVal[7:0];
         OFF_SRC_HI: rdData = srcVal[15:8];
         OFF_DST_LO: rdData = dstVal[7:0];
         OFF_DST_HI: rdData = dstVal[15:8];
         OFF_LEN_LO: rdData = lenVal[7:0];
         OFF_LEN_HI: rdData = lenVal[15:8];
         OFF_CTRL:   rdData = {5'b0, aborted, done, busy};
         default:    rdData = 8'h00;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         srcVal <= '0;
         dstVal <= '0;
         lenVal <= '0;
         done <= 1'b0;
         aborted <= 1'b0;
         cfgDout <= '0;
      end else begin
         if (cfgWEn && hit && !busy)
            case (off[2:0])
               OFF_SRC_LO: srcVal[7:0] <= cfgDin;
               OFF_SRC_HI: srcVal[15:8] <= cfgDin;
               OFF_DST_LO: dstVal[7:0] <= cfgDin;
               OFF_DST_HI: dstVal[15:8] <= cfgDin;
               OFF_LEN_LO: lenVal[7:0] <= cfgDin;
               OFF_LEN_HI: lenVal[15:8] <= cfgDin;
               default: ;
            endcase
         if (startStb) begin
            done <= 1'b0;
            aborted <= 1'b0;
         end
         if (doneSet) done <= 1'b1;
         if (abortSet) aborted <= 1'b1;
         if (cfgREn && hit) cfgDout <= rdData;
      end
   end
endmodule

// File: rtl/dma_engine.sv
// dma_engine: bus-mastering byte copier with register interface; define DMA_FILL_EN for constant-fill mode
module dma_engine
   import dma_pkg::*;
#(
   parameter logic [15:0] REG_BASE = 16'h1010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cfg_address,
   input  logic [7:0]  cfg_din,
   input  logic        cfg_w_en,
   input  logic        cfg_r_en,
   output logic [7:0]  cfg_dout,
   output logic        bus_req,
   input  logic        bus_gnt,
   output logic [15:0] m_addr,
   output logic [7:0]  m_wdata,
   input  logic [7:0]  m_rdata,
   output logic        m_re,
   output logic        m_we,
   output logic        irq
);
   dmaState state;
   logic [15:0] addrS, addrD, cnt, srcVal, dstVal, lenVal;
   logic [7:0] dataBuf;
   logic fillMode, reQ, weQ, busy, doneSet, startStb, abortStb, fillSel;
   assign busy = state inside {REQ, RD, CAP, WR};
   assign doneSet = (state == WR && bus_gnt && cnt == 16'd1 && !abortStb) ||
                    ((state == IDLE || state == FIN) && startStb && lenVal == 16'd0);
   // a lost grant or a pending abort must suppress the strobe in the very cycle it happens
   assign m_re = reQ && bus_gnt;
   assign m_we = weQ && bus_gnt && !abortStb;
   dma_regs #(.REG_BASE(REG_BASE)) regs (
      .clk(clk), .rst(rst), .cfgAddress(cfg_address), .cfgDin(cfg_din),
      .cfgWEn(cfg_w_en), .cfgREn(cfg_r_en), .busy(busy), .doneSet(doneSet),
      .abortSet(abortStb), .startStb(startStb), .abortStb(abortStb), .fillSel(fillSel),
      .srcVal(srcVal), .dstVal(dstVal), .lenVal(lenVal), .cfgDout(cfg_dout)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addrS <= '0;
         addrD <= '0;
         cnt <= '0;
         dataBuf <= '0;
         fillMode <= 1'b0;
         bus_req <= 1'b0;
         reQ <= 1'b0;
         weQ <= 1'b0;
         m_addr <= '0;
         m_wdata <= '0;
         irq <= 1'b0;
      end else begin
         irq <= 1'b0;
         reQ <= 1'b0;
         weQ <= 1'b0;
         if (abortStb) begin
            state <= FIN;
            bus_req <= 1'b0;
            irq <= 1'b1;
         end else
            case (state)
               IDLE, FIN: begin
                  state <= IDLE;
                  bus_req <= 1'b0;
                  if (startStb) begin
                     addrS <= srcVal;
                     addrD <= dstVal;
                     cnt <= lenVal;
                     dataBuf <= srcVal[7:0];
                     fillMode <= fillSel;
                     state <= lenVal == 16'd0 ? FIN : REQ;
                     irq <= lenVal == 16'd0;
                     bus_req <= lenVal != 16'd0;
                  end
               end
               REQ: if (bus_gnt) begin
                  state <= fillMode ? WR : RD;
                  reQ <= !fillMode;
                  weQ <= fillMode;
                  m_addr <= fillMode ? addrD : addrS;
                  m_wdata <= dataBuf;
               end
               RD: begin
                  reQ <= !bus_gnt;
                  if (bus_gnt) state <= CAP;
               end
               CAP: if (bus_gnt) begin
                  dataBuf <= m_rdata;
                  m_wdata <= m_rdata;
                  m_addr <= addrD;
                  weQ <= 1'b1;
                  state <= WR;
               end else begin
                  state <= RD;
                  reQ <= 1'b1;
               end
               WR: if (!bus_gnt)
                  weQ <= 1'b1;
               else begin
                  addrS <= addrS + 16'd1;
                  addrD <= addrD + 16'd1;
                  cnt <= cnt - 16'd1;
                  if (cnt == 16'd1) begin
                     state <= FIN;
                     bus_req <= 1'b0;
                     irq <= 1'b1;
                  end else if (fillMode) begin
                     weQ <= 1'b1;
                     m_addr <= addrD + 16'd1;
                  end else begin
                     state <= RD;
                     reQ <= 1'b1;
                     m_addr <= addrS + 16'd1;
                  end
               end
               default: state <= IDLE;
            endcase
      end
   end
endmodule

// File: tb/tb_dma_engine.sv
// tb_dma_engine: directed and randomized checks of dma_engine against a flat-memory copy model
module tb_dma_engine;
   localparam logic [15:0] REG_BASE = 16'h1010;
   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] cfg_address = '0;
   logic [7:0] cfg_din = '0, cfg_dout, m_wdata, m_rdata = '0;
   logic cfg_w_en = 1'b0, cfg_r_en = 1'b0, bus_req, bus_gnt = 1'b1, m_re, m_we, irq;
   logic [15:0] m_addr;
   logic [7:0] mem [65536];
   logic [7:0] refMem [65536];
   logic [15:0] rdQ[$], wrQ[$];
   logic [7:0] wdQ[$];
   int irqCnt = 0, viol = 0, gntMode = 0, checks = 0, errors = 0;

   dma_engine #(.REG_BASE(REG_BASE)) dut (
      .clk(clk), .rst(rst), .cfg_address(cfg_address), .cfg_din(cfg_din),
      .cfg_w_en(cfg_w_en), .cfg_r_en(cfg_r_en), .cfg_dout(cfg_dout),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_re(m_re), .m_we(m_we), .irq(irq)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      bus_gnt = gntMode == 0 ? 1'b1 : gntMode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
   end

   always @(posedge clk) begin
      if (m_re) begin
         m_rdata <= mem[m_addr];
         rdQ.push_back(m_addr);
      end
      if (m_we) begin
         mem[m_addr] <= m_wdata;
         wrQ.push_back(m_addr);
         wdQ.push_back(m_wdata);
      end
      if (irq) irqCnt <= irqCnt + 1;
      if ((m_re || m_we) && !(bus_gnt && bus_req)) viol <= viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wrReg(input int off, input logic [7:0] d);
      cfg_address = REG_BASE + 16'(off);
      cfg_din = d;
      cfg_w_en = 1'b1;
      @(posedge clk) #1;
      cfg_w_en = 1'b0;
   endtask

   task automatic rdReg(input int off, output logic [7:0] v);
      cfg_address = REG_BASE + 16'(off);
      cfg_r_en = 1'b1;
      @(posedge clk) #1;
      cfg_r_en = 1'b0;
      v = cfg_dout;
   endtask

   task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
      wrReg(0, s[7:0]);
      wrReg(1, s[15:8]);
      wrReg(2, d[7:0]);
      wrReg(3, d[15:8]);
      wrReg(4, n[7:0]);
      wrReg(5, n[15:8]);
   endtask

   task automatic waitIrq(input int maxCyc, output int n);
      n = -1;
      for (int i = 1; i <= maxCyc; i++) begin
         @(posedge clk) #1;
         if (irq) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic copyModel(input logic [15:0] s, input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) refMem[d + 16'(i)] = refMem[s + 16'(i)];
   endtask

   initial begin
      logic [7:0] v, regVals [6];
      logic [15:0] src, dst;
      int len, n, r0, w0, i0;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'($urandom);
         refMem[i] = mem[i];
      end
      regVals = '{8'h34, 8'h12, 8'h78, 8'h56, 8'h0B, 8'h00};
      idle(3);
      check("reset_outputs", {bus_req, m_re, m_we, irq, m_addr, m_wdata, cfg_dout}, '0);
      rst = 1'b0;
      rdReg(6, v);
      check("reset_status", v, 8'h00);
      for (int i = 0; i < 6; i++) wrReg(i, regVals[i]);
      for (int i = 0; i < 6; i++) begin
         rdReg(i, v);
         check($sformatf("readback_%0d", i), v, regVals[i]);
      end
      rdReg(7, v);
      check("out_of_range_holds", cfg_dout, regVals[5]);

      // directed copy, grant tied high
      for (int i = 0; i < 4; i++) begin
         mem[16'h0100 + 16'(i)] = 8'hA1 + 8'(i * 8'h11);
         refMem[16'h0100 + 16'(i)] = mem[16'h0100 + 16'(i)];
      end
      prog(16'h0100, 16'h2000, 16'd4);
      r0 = rdQ.size(); w0 = wrQ.size(); i0 = irqCnt;
      wrReg(6, 8'h01);
      check("copy_req_t1", bus_req, 1'b1);
      waitIrq(50, n);
      check("copy_cycles", n, 13);
      rdReg(6, v);
      check("copy_status", v, 8'h02);
      idle(2);
      check("copy_irq_once", irqCnt - i0, 1);
      check("copy_reads", rdQ.size() - r0, 4);
      check("copy_writes", wrQ.size() - w0, 4);
      copyModel(16'h0100, 16'h2000, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("copy_mem_%0d", i), mem[16'h2000 + 16'(i)], 8'hA1 + 8'(i * 8'h11));

      // zero length
      prog(16'h0200, 16'h0300, 16'd0);
      r0 = rdQ.size(); w0 = wrQ.size(); i0 = irqCnt;
      wrReg(6, 8'h01);
      check("len0_irq", irq, 1'b1);
      rdReg(6, v);
      check("len0_status", v, 8'h02);
      idle(3);
      check("len0_no_bus", (rdQ.size() - r0) + (wrQ.size() - w0), 0);
      check("len0_irq_once", irqCnt - i0, 1);

      // address wrap
      prog(16'hFFFF, 16'h0010, 16'd2);
      r0 = rdQ.size();
      wrReg(6, 8'h01);
      waitIrq(50, n);
      check("wrap_cycles", n, 7);
      idle(1);
      check("wrap_rd0", rdQ[r0], 16'hFFFF);
      check("wrap_rd1", rdQ[r0 + 1], 16'h0000);
      copyModel(16'hFFFF, 16'h0010, 2);
      for (int i = 0; i < 2; i++) check("wrap_mem", mem[16'h0010 + 16'(i)], refMem[16'h0010 + 16'(i)]);

      // grant withdrawn for 5 cycles while capturing byte 2 of 3
      prog(16'h0300, 16'h0400, 16'd3);
      r0 = rdQ.size(); w0 = wrQ.size(); i0 = viol;
      wrReg(6, 8'h01);
      idle(5);
      gntMode = 2;
      idle(5);
      gntMode = 0;
      waitIrq(60, n);
      check("gnt_done", n > 0, 1'b1);
      idle(1);
      check("gnt_reread", rdQ.size() - r0, 4);
      check("gnt_rd_addr", rdQ[r0 + 2], 16'h0301);
      check("gnt_writes", wrQ.size() - w0, 3);
      check("gnt_no_strobe_without_grant", viol - i0, 0);
      copyModel(16'h0300, 16'h0400, 3);
      for (int i = 0; i < 4; i++) check("gnt_mem", mem[16'h0400 + 16'(i)], refMem[16'h0400 + 16'(i)]);

      // abort after the first byte of eight
      prog(16'h0500, 16'h0600, 16'd8);
      w0 = wrQ.size(); i0 = irqCnt;
      wrReg(6, 8'h01);
      wrReg(0, 8'hEE);
      for (int i = 0; i < 40 && wrQ.size() - w0 < 1; i++) idle(1);
      wrReg(6, 8'h04);
      check("abort_req_low", bus_req, 1'b0);
      check("abort_irq", irq, 1'b1);
      idle(6);
      check("abort_one_write", wrQ.size() - w0, 1);
      check("abort_irq_once", irqCnt - i0, 1);
      rdReg(6, v);
      check("abort_status", v, 8'h04);
      rdReg(0, v);
      check("busy_write_ignored", v, 8'h00);
      copyModel(16'h0500, 16'h0600, 1);
      for (int i = 0; i < 2; i++) check("abort_mem", mem[16'h0600 + 16'(i)], refMem[16'h0600 + 16'(i)]);

      // START together with ABORT while idle
      prog(16'h0700, 16'h0800, 16'd2);
      r0 = rdQ.size();
      wrReg(6, 8'h05);
      check("start_abort_no_req", bus_req, 1'b0);
      idle(4);
      rdReg(6, v);
      check("start_abort_status", v, 8'h04);
      check("start_abort_no_reads", rdQ.size() - r0, 0);

`ifdef DMA_FILL_EN
      prog(16'h0055, 16'h2100, 16'd3);
      r0 = rdQ.size(); w0 = wrQ.size();
      wrReg(6, 8'h03);
      waitIrq(20, n);
      check("fill_cycles", n, 4);
      idle(1);
      check("fill_reads", rdQ.size() - r0, 0);
      check("fill_writes", wrQ.size() - w0, 3);
      for (int i = 0; i < 3; i++) begin
         refMem[16'h2100 + 16'(i)] = 8'h55;
         check("fill_data", mem[16'h2100 + 16'(i)], 8'h55);
      end
`endif

      // randomized copies under a random grant
      for (int t = 0; t < 20; t++) begin
         src = 16'($urandom);
         dst = 16'($urandom);
         len = $urandom_range(1, 12);
         gntMode = 1;
         prog(src, dst, 16'(len));
         w0 = wrQ.size(); i0 = irqCnt;
         wrReg(6, 8'h01);
         check("rnd_req", bus_req, 1'b1);
         waitIrq(100 + 30 * len, n);
         check("rnd_irq_seen", n > 0, 1'b1);
         rdReg(6, v);
         check("rnd_status", v, 8'h02);
         check("rnd_irq_once", irqCnt - i0, 1);
         check("rnd_writes", wrQ.size() - w0, len);
         copyModel(src, dst, len);
         for (int i = 0; i <= len; i++)
            check($sformatf("rnd%0d_mem_%0d", t, i), mem[dst + 16'(i)], refMem[dst + 16'(i)]);
      end
      gntMode = 0;
      idle(1);
      check("rnd_grant_respected", viol, 0);

      // reset in the middle of a transfer
      prog(16'h0900, 16'h0A00, 16'd8);
      wrReg(6, 8'h01);
      idle(5);
      rst = 1'b1;
      idle(1);
      check("rst_outputs", {bus_req, m_re, m_we, irq, m_addr, m_wdata, cfg_dout}, '0);
      r0 = rdQ.size(); w0 = wrQ.size();
      rst = 1'b0;
      idle(5);
      check("rst_no_bus", (rdQ.size() - r0) + (wrQ.size() - w0), 0);
      rdReg(6, v);
      check("rst_status", v, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
